// File: rtl/uart_rx_engine_if.sv
// Received-character bus: engine drives data/status, consumer returns clr_rdy.
`timescale 1ns/1ps
interface uart_rx_engine_if;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  modport master (input clr_rdy, output rx_data, rx_rdy, perr, ferr, ovf);
  modport slave  (output clr_rdy, input rx_data, rx_rdy, perr, ferr, ovf);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop sync, mid-bit sampling, 7/8 data bits; status updates on the stop-bit sample.
// Optional parity state and perr checking are built only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_engine #(
  parameter int BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [BAUD_W-1:0] k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  uart_rx_engine_if.master  bus
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [BAUD_W-1:0] ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              rx_meta, rxs;
  logic [BAUD_W-1:0] cnt, k_l;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh;
  logic              eight_l;
  logic              brk;
  logic [7:0]        data_q;
  logic              rdy_q, ferr_q, ovf_q;
  logic              tick;
  logic [7:0]        rcv;

  assign tick = (cnt <= ONE);
  // 7-bit frames leave their bits in sh[7:1]
  assign rcv  = eight_l ? sh : {1'b0, sh[7:1]};

`ifdef UART_RX_PARITY_EN
  logic pen_l, ohel_l, par_q, perr_q;
  assign bus.perr = perr_q;
`else
  logic unused_cfg;
  assign unused_cfg = pen ^ ohel;
  assign bus.perr   = 1'b0;
`endif

  assign bus.rx_data = data_q;
  assign bus.rx_rdy  = rdy_q;
  assign bus.ferr    = ferr_q;
  assign bus.ovf     = ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      cnt     <= '0;
      k_l     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      eight_l <= 1'b0;
      brk     <= 1'b0;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pen_l   <= 1'b0;
      ohel_l  <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      if (bus.clr_rdy) rdy_q <= 1'b0;
      if (state != IDLE && !tick) cnt <= cnt - ONE;
      case (state)
        IDLE: begin
          // after a break the line must go high again before a new start counts
          if (brk) begin
            if (rxs) brk <= 1'b0;
          end else if (!rxs) begin
            k_l     <= k;
            eight_l <= eight;
`ifdef UART_RX_PARITY_EN
            pen_l   <= pen;
            ohel_l  <= ohel;
`endif
            cnt     <= k >> 1;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: if (tick) begin
          if (rxs) state <= IDLE;
          else begin
            cnt   <= k_l;
            state <= DATA;
          end
        end
        DATA: if (tick) begin
          sh  <= {rxs, sh[7:1]};
          cnt <= k_l;
          if (bit_cnt == {2'b11, eight_l}) begin
`ifdef UART_RX_PARITY_EN
            state <= pen_l ? PARITY : STOP;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          par_q <= rxs;
          cnt   <= k_l;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          state  <= IDLE;
          data_q <= rcv;
          rdy_q  <= 1'b1;
          ferr_q <= ~rxs;
          ovf_q  <= rdy_q & ~bus.clr_rdy;
          brk    <= ~rxs;
`ifdef UART_RX_PARITY_EN
          perr_q <= pen_l & (((^rcv) ^ par_q) != ohel_l);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboarded bench for uart_rx_engine: directed frames plus randomized frames vs. a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_engine;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [18:0] k_in = 19'd16;
  logic        eight = 1'b1;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;

  int   checks = 0;
  int   errors = 0;
  bit   model_rdy = 1'b0;
  exp_t q[$];

  uart_rx_engine_if bus();

  uart_rx_engine #(.BAUD_W(19)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .k     (k_in),
    .eight (eight),
    .pen   (pen),
    .ohel  (ohel),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
    model_rdy   = 1'b0;
  endtask

  // One frame on the line; expectation is derived from the frame contents.
  // clr_done places clr_rdy on the stop-sample clock: sync (2) + idle detect (1) + half bit + whole bits.
  task automatic send_frame(input logic [7:0] d, input int kk, input bit e8, input bit pe,
                            input bit od, input bit pbit, input bit stopv,
                            input bit clr_done, input bit clr_after);
    int         bits, nb, done, total;
    bit         epen;
    logic       fr[0:11];
    logic [7:0] m;
    exp_t       x;
    epen  = pe & PAR_EN;
    bits  = e8 ? 8 : 7;
    nb    = bits + int'(epen);
    k_in  = 19'(kk);
    eight = e8;
    pen   = pe;
    ohel  = od;
    m     = e8 ? d : {1'b0, d[6:0]};
    x.d   = m;
    x.f   = ~stopv;
    x.p   = epen && (((^m) ^ pbit) != od);
    x.o   = model_rdy && !clr_done;
    q.push_back(x);
    model_rdy = 1'b1;
    for (int b = 0; b < 12; b++) fr[b] = 1'b1;
    fr[0] = 1'b0;
    for (int b = 0; b < bits; b++) fr[1 + b] = d[b];
    if (epen) fr[bits + 1] = pbit;
    fr[nb + 1] = stopv;
    done  = 3 + kk / 2 + (nb + 1) * kk;
    total = (nb + 3) * kk;
    for (int i = 0; i < total; i++) begin
      rx          = fr[i / kk];
      bus.clr_rdy = clr_done && (i == done - 1);
      if (i == kk) begin
        k_in  = 19'($urandom_range(40, 4));
        eight = 1'($urandom);
        pen   = 1'($urandom);
        ohel  = 1'($urandom);
      end
      tick(1);
    end
    bus.clr_rdy = 1'b0;
    rx          = 1'b1;
    if (clr_after) pulse_clr();
  endtask

  // Monitor: a completion shows as rx_rdy rising, or new status while rx_rdy stays high.
  initial begin : monitor
    logic       prev_rdy, prev_p, prev_f, prev_o;
    logic [7:0] prev_d;
    exp_t       x;
    prev_rdy = 1'b0; prev_p = 1'b0; prev_f = 1'b0; prev_o = 1'b0; prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (reset && bus.rx_rdy &&
          (!prev_rdy || bus.rx_data != prev_d || bus.perr != prev_p ||
           bus.ferr != prev_f || bus.ovf != prev_o)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got data %0h with nothing expected at %0t", bus.rx_data, $time);
        end else begin
          x = q.pop_front();
          check("rx_data", bus.rx_data, x.d);
          check("perr", bus.perr, x.p);
          check("ferr", bus.ferr, x.f);
          check("ovf", bus.ovf, x.o);
        end
      end
      prev_rdy = bus.rx_rdy; prev_d = bus.rx_data;
      prev_p = bus.perr; prev_f = bus.ferr; prev_o = bus.ovf;
    end
  end

  initial begin : watchdog
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.clr_rdy = 1'b0;
    #2;
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_rdy", bus.rx_rdy, 1'b0);
    check("reset_perr", bus.perr, 1'b0);
    check("reset_ferr", bus.ferr, 1'b0);
    check("reset_ovf", bus.ovf, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(5);

    send_frame(8'hA5, 16, 1, 0, 0, 0, 1, 0, 1);
    send_frame(8'h3C, 16, 1, 1, 0, 1, 1, 0, 1);
    send_frame(8'h3C, 16, 1, 1, 0, 0, 1, 0, 1);
    send_frame(8'h7F, 16, 0, 0, 0, 0, 0, 0, 1);
    tick(32);
    send_frame(8'h55, 16, 0, 0, 0, 0, 1, 0, 1);

    // false start: 4-clock glitch must not produce a frame
    k_in = 19'd16; eight = 1'b1; pen = 1'b0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("false_start_rdy", bus.rx_rdy, 1'b0);
    send_frame(8'h81, 16, 1, 0, 0, 0, 1, 0, 1);

    send_frame(8'h11, 16, 1, 0, 0, 0, 1, 0, 0);
    send_frame(8'h22, 16, 1, 0, 0, 0, 1, 0, 0);
    pulse_clr();
    send_frame(8'h11, 16, 1, 0, 0, 0, 1, 0, 0);
    send_frame(8'h22, 16, 1, 0, 0, 0, 1, 1, 0);
    check("clr_coincide_rdy", bus.rx_rdy, 1'b1);
    pulse_clr();
    check("clr_rdy_clears", bus.rx_rdy, 1'b0);

    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), int'($urandom_range(40, 4)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(4, 0) != 0), 0, 1);
    end

    // leave a frame pending, then reset in the middle of 0xFF's data bits
    send_frame(8'h5A, 16, 1, 0, 0, 0, 1, 0, 0);
    k_in = 19'd16; eight = 1'b1; pen = 1'b0;
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    reset = 1'b0;
    #1;
    check("midreset_rx_data", bus.rx_data, 8'h00);
    check("midreset_rx_rdy", bus.rx_rdy, 1'b0);
    check("midreset_perr", bus.perr, 1'b0);
    check("midreset_ferr", bus.ferr, 1'b0);
    check("midreset_ovf", bus.ovf, 1'b0);
    model_rdy = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(200);
    send_frame(8'h0F, 16, 1, 0, 0, 0, 1, 0, 1);

    tick(100);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
